// File: rtl/mod15_sched_pkg.sv
// Shared types for the mod-15 counter scheduler.
// Op codes, FSM states and the counter modulus.
package mod15_sched_pkg;

  localparam int MOD = 15;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_RUN,
    S_SETTLE,
    S_DONE
  } state_e;

endpackage

// File: rtl/mod15_rr_arb.sv
// Round-robin arbiter: search from the pointer, grant first requester.
// Pointer moves past the winner whenever adv is strobed.
module mod15_rr_arb #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req,
  input  logic             adv,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    int   k;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_q) + i) % NREQ;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else if (adv) begin
      ptr_q <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mod15_cnt_sched.sv
// Shares one external mod-15 counter between NREQ requesters.
// Commands are serialised; every output is registered.
module mod15_cnt_sched #(
  parameter int NREQ   = 2,
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*2-1:0]        req_op,
  input  logic [NREQ*STEP_W-1:0]   req_arg,
  output logic                     cnt_load,
  output logic                     cnt_mode,
  output logic                     cnt_en,
  output logic [WIDTH-1:0]         cnt_din,
  input  logic [WIDTH-1:0]         cnt_dout,
  output logic                     done_valid,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [WIDTH-1:0]         done_count
);

  import mod15_sched_pkg::*;

  localparam int IDX_W = $clog2(NREQ);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [STEP_W-1:0]   arg_q, arg_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [IDX_W-1:0]    id_q, id_d;

  logic [NREQ-1:0]     ready_d;
  logic                load_d, mode_d, en_d, dv_d;
  logic [WIDTH-1:0]    din_d, dcnt_d;
  logic [IDX_W-1:0]    did_d;

  logic [NREQ-1:0]     gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                adv;

  assign adv = (state_q == S_IDLE) && (|req_valid);

  mod15_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clock   (clock),
    .resetn  (resetn),
    .req     (req_valid),
    .adv     (adv),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    steps_d = steps_q;
    id_d    = id_q;
    ready_d = '0;
    load_d  = 1'b0;
    mode_d  = 1'b0;
    en_d    = 1'b0;
    din_d   = '0;
    dv_d    = 1'b0;
    did_d   = '0;
    dcnt_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          ready_d = gnt;
          id_d    = gnt_idx;
          for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
              op_d  = op_e'(req_op[2*i +: 2]);
              arg_d = req_arg[STEP_W*i +: STEP_W];
            end
          end
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_LOAD: begin
            load_d  = 1'b1;
            din_d   = WIDTH'(arg_q[WIDTH-1:0] % MOD);
            state_d = S_SETTLE;
          end
          OP_UP, OP_DOWN: begin
            if (arg_q != '0) begin
              en_d    = 1'b1;
              mode_d  = (op_q == OP_UP);
              steps_d = arg_q - 1'b1;
              state_d = (arg_q == STEP_W'(1)) ? S_SETTLE : S_RUN;
            end else begin
              state_d = S_DONE;
            end
          end
          default: state_d = S_DONE;
        endcase
      end
      S_RUN: begin
        en_d    = 1'b1;
        mode_d  = (op_q == OP_UP);
        steps_d = steps_q - 1'b1;
        if (steps_q == STEP_W'(1)) state_d = S_SETTLE;
      end
      // strobes idle for one edge so cnt_dout is final in DONE
      S_SETTLE: state_d = S_DONE;
      S_DONE: begin
        dv_d    = 1'b1;
        did_d   = id_q;
        dcnt_d  = cnt_dout;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      arg_q      <= '0;
      steps_q    <= '0;
      id_q       <= '0;
      req_ready  <= '0;
      cnt_load   <= 1'b0;
      cnt_mode   <= 1'b0;
      cnt_en     <= 1'b0;
      cnt_din    <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_count <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      steps_q    <= steps_d;
      id_q       <= id_d;
      req_ready  <= ready_d;
      cnt_load   <= load_d;
      cnt_mode   <= mode_d;
      cnt_en     <= en_d;
      cnt_din    <= din_d;
      done_valid <= dv_d;
      done_id    <= did_d;
      done_count <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_mod15_cnt_sched.sv
// Bench for mod15_cnt_sched: directed cases then random commands,
// checked against an arithmetic model of the scheduler and counter.
module tb_mod15_cnt_sched;

  localparam int NREQ   = 2;
  localparam int WIDTH  = 4;
  localparam int STEP_W = 8;
  localparam int BOUND  = 300;

  logic                    clock = 1'b0;
  logic                    resetn;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*2-1:0]       req_op;
  logic [NREQ*STEP_W-1:0]  req_arg;
  logic                    cnt_load, cnt_mode, cnt_en;
  logic [WIDTH-1:0]        cnt_din;
  logic [WIDTH-1:0]        cnt_dout = '0;
  logic                    done_valid;
  logic [0:0]              done_id;
  logic [WIDTH-1:0]        done_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ptr_m = 0;
  int ref_cnt = 0;

  mod15_cnt_sched #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_arg    (req_arg),
    .cnt_load   (cnt_load),
    .cnt_mode   (cnt_mode),
    .cnt_en     (cnt_en),
    .cnt_din    (cnt_din),
    .cnt_dout   (cnt_dout),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_count (done_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // external mod-15 counter, never reset
  always @(posedge clock) begin
    if (cnt_load)
      cnt_dout <= cnt_din;
    else if (cnt_en)
      cnt_dout <= cnt_mode ? 4'((int'(cnt_dout) + 1) % 15)
                           : 4'((int'(cnt_dout) + 14) % 15);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic int exp_count(input int cur, input int op,
                                   input int arg);
    case (op)
      0:       return (arg % 16) % 15;
      1:       return (cur + arg) % 15;
      2:       return (cur + 15 - (arg % 15)) % 15;
      default: return cur;
    endcase
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({req_ready, cnt_load, cnt_mode, cnt_en, cnt_din,
                done_valid, done_id, done_count});
  endfunction

  // Called just after a negedge; returns at the negedge showing done.
  task automatic run_cmd(input logic [NREQ-1:0] vld,
                         input logic [1:0] op0, input logic [1:0] op1,
                         input logic [7:0] a0, input logic [7:0] a1);
    int g, op, arg, waited, tc, e_cnt, e_lat, e_en;
    int nen, nld, first_en, last_en;
    bit seen;
    req_valid = vld;
    req_op    = {op1, op0};
    req_arg   = {a1, a0};
    if (vld == '0) begin
      repeat (3) begin
        @(negedge clock);
        chk("no_grant", 32'(req_ready), 0);
      end
      return;
    end
    g = rr_pick(vld, ptr_m);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (req_ready == '0 && waited < 8);
    chk("acc_lat", waited, 1);
    chk("grant", 32'(req_ready), 32'(1 << g));
    tc    = cyc;
    ptr_m = (g + 1) % NREQ;
    op    = (g == 0) ? int'(op0) : int'(op1);
    arg   = (g == 0) ? int'(a0) : int'(a1);
    req_valid[g] = 1'b0;
    e_cnt = exp_count(ref_cnt, op, arg);
    e_en  = (op == 1 || op == 2) ? arg : 0;
    e_lat = (op == 0) ? 3 : (e_en > 0 ? e_en + 2 : 2);
    nen = 0; nld = 0; first_en = -1; last_en = -1; seen = 0;
    for (int k = 0; k < BOUND && !seen; k++) begin
      @(negedge clock);
      chk("rdy_busy", 32'(req_ready), 0);
      chk("ld_en_excl", 32'(cnt_load & cnt_en), 0);
      if (cnt_en) begin
        nen++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        chk("mode", 32'(cnt_mode), 32'(op == 1));
      end
      if (cnt_load) begin
        nld++;
        chk("din", 32'(cnt_din), 32'((arg % 16) % 15));
        chk("ld_cyc", cyc - tc, 1);
      end
      if (done_valid) seen = 1;
    end
    chk("done_seen", 32'(seen), 1);
    chk("latency", cyc - tc, e_lat);
    chk("done_id", 32'(done_id), g);
    chk("done_count", 32'(done_count), e_cnt);
    chk("n_en", nen, e_en);
    chk("n_load", nld, 32'(op == 0));
    if (nen > 0) begin
      chk("en_first", first_en - tc, 1);
      chk("en_last", last_en - tc, e_en);
    end
    ref_cnt = e_cnt;
  endtask

  initial begin
    int waited, nen, g;
    resetn    = 1'b0;
    req_valid = '1;
    req_op    = '0;
    req_arg   = '0;
    repeat (3) @(negedge clock);
    chk("rst_outs", all_outs(), 0);
    resetn = 1'b1;

    run_cmd(2'b11, 2'd0, 2'd1, 8'd9, 8'd20);
    run_cmd(2'b10, 2'd0, 2'd1, 8'd9, 8'd20);
    run_cmd(2'b01, 2'd0, 2'd3, 8'd1, 8'd0);
    run_cmd(2'b01, 2'd2, 2'd3, 8'd3, 8'd0);
    run_cmd(2'b10, 2'd3, 2'd1, 8'd0, 8'd0);
    repeat (4) run_cmd(2'b11, 2'd0, 2'd0, 8'd5, 8'd7);
    run_cmd(2'b01, 2'd0, 2'd3, 8'd15, 8'd0);

    // abort an UP 10 after five enables
    req_valid = 2'b01;
    req_op    = {2'd3, 2'd1};
    req_arg   = {8'd0, 8'd10};
    g = rr_pick(req_valid, ptr_m);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (req_ready == '0 && waited < 8);
    chk("abort_grant", 32'(req_ready), 32'(1 << g));
    req_valid = '0;
    nen = 0;
    for (int k = 0; k < 20 && nen < 5; k++) begin
      @(negedge clock);
      if (cnt_en) nen++;
    end
    chk("abort_en5", nen, 5);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1 chk("abort_outs", all_outs(), 0);
    ptr_m   = 0;
    ref_cnt = (ref_cnt + 5) % 15;
    req_valid = '1;
    repeat (3) begin
      @(negedge clock);
      chk("abort_nodone", 32'(done_valid), 0);
      chk("abort_rdy", 32'(req_ready), 0);
    end
    resetn = 1'b1;
    run_cmd(2'b11, 2'd1, 2'd1, 8'd0, 8'd0);

    for (int it = 0; it < 40; it++) begin
      logic [1:0] v, o0, o1;
      logic [7:0] x0, x1;
      v  = 2'($urandom_range(0, 3));
      o0 = 2'($urandom_range(0, 3));
      o1 = 2'($urandom_range(0, 3));
      x0 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 20));
      x1 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 20));
      run_cmd(v, o0, o1, x0, x1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
